// File: rtl/fsm_conv_pkg.sv
// Shared types and constants for the float-to-fixed conversion control FSM.
package fsm_conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_COMPARE = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_WAIT_SH = 3'd4,
        ST_STORE   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [7:0] EXP_BIAS = 8'd127;
    localparam int         CNT_W    = 4;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter that times out the shifter latency; zero flags expiry.
module wait_counter
    import fsm_conv_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fsm_convert_float_to_fixed.sv
// Control FSM for one float-to-fixed conversion per request.
// Optional range-error flag OVF is built when CONV_OVF_DETECT_EN is defined.
module fsm_convert_float_to_fixed
    import fsm_conv_pkg::*;
#(
    parameter int SHIFT_LAT  = 1,
    parameter int MAX_LSHIFT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BEGIN_FSM,
    input  logic       ACK_FSM,
    input  logic       Exp_out,
    input  logic [7:0] Exp,
    output logic       EN_REG1,
    output logic       LOAD,
    output logic       MS_1,
    output logic       EN_REG2,
    output logic       BUSY,
    output logic       READY,
`ifdef CONV_OVF_DETECT_EN
    output logic       OVF,
`endif
    output logic [2:0] fsm_state
);

    state_t state;
    state_t next_state;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;

    wait_counter #(
        .W(CNT_W)
    ) u_wait_counter (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (CNT_W'(SHIFT_LAT - 1)),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake: READY (valid) stays high in DONE until ACK_FSM is seen
    // there; a held BEGIN_FSM is only honoured once IDLE has been reached.
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:    next_state = BEGIN_FSM ? ST_LATCH : ST_IDLE;
            ST_LATCH:   next_state = ST_COMPARE;
            ST_COMPARE: next_state = ST_SHIFT;
            ST_SHIFT:   next_state = ST_WAIT_SH;
            ST_WAIT_SH: next_state = cnt_zero ? ST_STORE : ST_WAIT_SH;
            ST_STORE:   next_state = ST_DONE;
            ST_DONE:    next_state = ACK_FSM ? ST_IDLE : ST_DONE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        EN_REG1  = 1'b0;
        LOAD     = 1'b0;
        MS_1     = 1'b0;
        EN_REG2  = 1'b0;
        BUSY     = (state != ST_IDLE);
        READY    = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state)
            ST_LATCH:   EN_REG1 = 1'b1;
            ST_SHIFT: begin
                LOAD     = 1'b1;
                MS_1     = (Exp != EXP_BIAS);
                cnt_load = 1'b1;
            end
            ST_WAIT_SH: cnt_dec = 1'b1;
            ST_STORE:   EN_REG2 = 1'b1;
            ST_DONE:    READY = 1'b1;
            default: ;
        endcase
    end

    assign fsm_state = state;

`ifdef CONV_OVF_DETECT_EN
    logic [7:0] lshift;
    logic       ovf_calc;
    logic       ovf_q;

    // lshift is only meaningful when Exp_out says Exp > bias.
    assign lshift   = Exp - EXP_BIAS;
    assign ovf_calc = (Exp == 8'hFF) | (Exp_out & (lshift > 8'(MAX_LSHIFT)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (next_state == ST_STORE) begin
            ovf_q <= ovf_calc;
        end else if (next_state == ST_IDLE) begin
            ovf_q <= 1'b0;
        end
    end

    assign OVF = ovf_q;
`else
    logic [8:0] unused_ovf_inputs;
    assign unused_ovf_inputs = {Exp_out, 8'(MAX_LSHIFT)};
`endif

endmodule

// File: tb/tb_fsm_convert_float_to_fixed.sv
// Directed bench for fsm_convert_float_to_fixed at SHIFT_LAT=1 and SHIFT_LAT=3.
module tb_fsm_convert_float_to_fixed;

    // Output vector order: {EN_REG1, LOAD, MS_1, EN_REG2, BUSY, READY}
    localparam logic [5:0] V_IDLE  = 6'b000000;
    localparam logic [5:0] V_LATCH = 6'b100010;
    localparam logic [5:0] V_CMP   = 6'b000010;
    localparam logic [5:0] V_SH0   = 6'b010010;
    localparam logic [5:0] V_SH1   = 6'b011010;
    localparam logic [5:0] V_WAIT  = 6'b000010;
    localparam logic [5:0] V_STORE = 6'b000110;
    localparam logic [5:0] V_DONE  = 6'b000011;

    logic       clk;
    logic       rst;
    logic       begin_fsm, ack_fsm, begin3, ack3;
    logic       exp_out;
    logic [7:0] exp_v;

    logic       en1_a, load_a, ms_a, en2_a, busy_a, ready_a;
    logic       en1_b, load_b, ms_b, en2_b, busy_b, ready_b;
    logic [2:0] st_a, st_b;
    logic [5:0] obs1, obs3;
`ifdef CONV_OVF_DETECT_EN
    logic       ovf_a, ovf_b;
`endif

    int checks   = 0;
    int failures = 0;
    logic [5:0] exp_q[$];

    fsm_convert_float_to_fixed #(.SHIFT_LAT(1), .MAX_LSHIFT(4)) dut1 (
        .CLK(clk), .RST(rst), .BEGIN_FSM(begin_fsm), .ACK_FSM(ack_fsm),
        .Exp_out(exp_out), .Exp(exp_v),
        .EN_REG1(en1_a), .LOAD(load_a), .MS_1(ms_a), .EN_REG2(en2_a),
        .BUSY(busy_a), .READY(ready_a),
`ifdef CONV_OVF_DETECT_EN
        .OVF(ovf_a),
`endif
        .fsm_state(st_a)
    );

    fsm_convert_float_to_fixed #(.SHIFT_LAT(3), .MAX_LSHIFT(4)) dut3 (
        .CLK(clk), .RST(rst), .BEGIN_FSM(begin3), .ACK_FSM(ack3),
        .Exp_out(exp_out), .Exp(exp_v),
        .EN_REG1(en1_b), .LOAD(load_b), .MS_1(ms_b), .EN_REG2(en2_b),
        .BUSY(busy_b), .READY(ready_b),
`ifdef CONV_OVF_DETECT_EN
        .OVF(ovf_b),
`endif
        .fsm_state(st_b)
    );

    assign obs1 = {en1_a, load_a, ms_a, en2_a, busy_a, ready_a};
    assign obs3 = {en1_b, load_b, ms_b, en2_b, busy_b, ready_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_conv(input logic ms, input int lat);
        exp_q.push_back(V_LATCH);
        exp_q.push_back(V_CMP);
        exp_q.push_back(ms ? V_SH1 : V_SH0);
        for (int i = 0; i < lat; i++) exp_q.push_back(V_WAIT);
        exp_q.push_back(V_STORE);
        exp_q.push_back(V_DONE);
    endtask

    // Step one cycle per queued vector and compare the chosen DUT against it.
    task automatic play(input string tag, input bit use3, input bit hold_begin);
        logic [5:0] v;
        while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            tick();
            if (!hold_begin) begin
                begin_fsm = 1'b0;
                begin3    = 1'b0;
            end
            chk(tag, use3 ? obs3 : obs1, v);
        end
    endtask

    task automatic ack_to_idle(input string tag);
        ack_fsm = 1'b1;
        tick();
        ack_fsm = 1'b0;
        chk({tag, "_state"}, st_a, 3'd0);
        chk({tag, "_outs"}, obs1, V_IDLE);
    endtask

`ifdef CONV_OVF_DETECT_EN
    task automatic ovf_case(input string tag, input logic [7:0] e, input logic eo, input logic want);
        exp_v     = e;
        exp_out   = eo;
        begin_fsm = 1'b1;
        tick();
        begin_fsm = 1'b0;
        repeat (3) tick();
        chk({tag, "_wait"}, ovf_a, 1'b0);
        tick();
        chk({tag, "_store"}, ovf_a, want);
        tick();
        chk({tag, "_done"}, ovf_a, want);
        tick();
        chk({tag, "_hold"}, ovf_a, want);
        ack_fsm = 1'b1;
        tick();
        ack_fsm = 1'b0;
        chk({tag, "_idle"}, ovf_a, 1'b0);
    endtask
`endif

    initial begin
        rst = 1'b1; begin_fsm = 1'b0; ack_fsm = 1'b0; begin3 = 1'b0; ack3 = 1'b0;
        exp_out = 1'b0; exp_v = 8'd127;
        tick();
        tick();
        chk("reset_state", st_a, 3'd0);
        chk("reset_outs", obs1, V_IDLE);
        chk("reset_outs3", obs3, V_IDLE);
`ifdef CONV_OVF_DETECT_EN
        chk("reset_ovf", ovf_a, 1'b0);
`endif
        rst = 1'b0;
        tick();

        // Exp = 127: zero shift, MS_1 stays low in SHIFT.
        exp_v = 8'd127; exp_out = 1'b0;
        begin_fsm = 1'b1;
        push_conv(1'b0, 1);
        play("exp127", 1'b0, 1'b0);
        tick();
        chk("exp127_hold", obs1, V_DONE);
        ack_to_idle("exp127_ack");

        // Exp = 128: MS_1 high only during SHIFT.
        exp_v = 8'd128; exp_out = 1'b1;
        begin_fsm = 1'b1;
        push_conv(1'b1, 1);
        play("exp128", 1'b0, 1'b0);
        ack_to_idle("exp128_ack");

        // BEGIN during WAIT_SH and ACK during SHIFT are ignored.
        exp_v = 8'd130;
        begin_fsm = 1'b1;
        tick();
        begin_fsm = 1'b0;
        tick();
        tick();
        chk("ign_shift", obs1, V_SH1);
        ack_fsm = 1'b1;
        tick();
        ack_fsm = 1'b0;
        chk("ign_wait_state", st_a, 3'd4);
        begin_fsm = 1'b1;
        tick();
        begin_fsm = 1'b0;
        chk("ign_store", obs1, V_STORE);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("ign_done_hold", obs1, V_DONE);
            tick();
        end
        ack_to_idle("ign_ack");
        tick();
        chk("ign_stay_idle", st_a, 3'd0);

        // Reset while in WAIT_SH aborts, then a normal conversion follows.
        exp_v = 8'd127; exp_out = 1'b0;
        begin_fsm = 1'b1;
        tick();
        begin_fsm = 1'b0;
        repeat (3) tick();
        chk("rst_mid_wait", st_a, 3'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_state", st_a, 3'd0);
        chk("rst_mid_outs", obs1, V_IDLE);
        begin_fsm = 1'b1;
        push_conv(1'b0, 1);
        play("after_rst", 1'b0, 1'b0);
        ack_to_idle("after_rst_ack");

        // BEGIN held through DONE->IDLE restarts one cycle after IDLE.
        begin_fsm = 1'b1;
        push_conv(1'b0, 1);
        play("held_begin", 1'b0, 1'b1);
        ack_fsm = 1'b1;
        tick();
        ack_fsm = 1'b0;
        chk("held_idle", obs1, V_IDLE);
        tick();
        begin_fsm = 1'b0;
        chk("held_restart", obs1, V_LATCH);
        exp_q.push_back(V_CMP);
        exp_q.push_back(V_SH0);
        exp_q.push_back(V_WAIT);
        exp_q.push_back(V_STORE);
        exp_q.push_back(V_DONE);
        play("held_rest", 1'b0, 1'b0);
        ack_to_idle("held_ack");

        // SHIFT_LAT = 3 instance: three WAIT_SH cycles, READY at c8.
        exp_v = 8'd128; exp_out = 1'b1;
        begin3 = 1'b1;
        push_conv(1'b1, 3);
        play("lat3", 1'b1, 1'b0);
        ack3 = 1'b1;
        tick();
        ack3 = 1'b0;
        chk("lat3_idle", st_b, 3'd0);
        chk("lat3_outs", obs3, V_IDLE);

`ifdef CONV_OVF_DETECT_EN
        ovf_case("ovf128", 8'd128, 1'b1, 1'b0);
        ovf_case("ovf135", 8'd135, 1'b1, 1'b1);
        ovf_case("ovf255", 8'd255, 1'b1, 1'b1);
        ovf_case("ovf131", 8'd131, 1'b1, 1'b0);
        ovf_case("ovf100", 8'd100, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
